// File: rtl/fc_muldecomp_pkg.sv
// fc_muldecomp_pkg: shared types and helpers for the FC multiply-decomposition pipeline.
package fc_muldecomp_pkg;

    typedef enum logic {MD_UNIPOLAR, MD_BIPOLAR} md_mode_e;

    function automatic int fold_w(int fold);
        return (fold > 1) ? $clog2(fold) : 1;
    endfunction

endpackage

// File: rtl/fc_muldecomp_stage.sv
// fc_muldecomp_stage: one pipeline register holding a beat's valid, products, enables and fold tag.
module fc_muldecomp_stage #(
    parameter int N  = 1,
    parameter int FW = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          adv,
    input  logic          in_valid,
    input  logic [N-1:0]  in_fm,
    input  logic [N-1:0]  in_en,
    input  logic [FW-1:0] in_fold,
    input  logic          in_last,
    output logic          out_valid,
    output logic [N-1:0]  out_fm,
    output logic [N-1:0]  out_en,
    output logic [FW-1:0] out_fold,
    output logic          out_last
);

    logic load;

    // Payload only toggles for real beats; bubbles leave stale data behind valid=0.
    assign load = adv & in_valid & ~flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_fm    <= '0;
            out_en    <= '0;
            out_fold  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (flush)
                out_valid <= 1'b0;
            else if (adv)
                out_valid <= in_valid;
            if (load) begin
                out_fm   <= in_fm;
                out_en   <= in_en;
                out_fold <= in_fold;
                out_last <= in_last;
            end
        end
    end

endmodule

// File: rtl/fc_muldecomp_pipe.sv
// fc_muldecomp_pipe: forms per-synapse product/enable bits and carries them with a fold tag
// through PIPE valid/ready register stages.
module fc_muldecomp_pipe
    import fc_muldecomp_pkg::*;
#(
    parameter int IDIM = 1,
    parameter int FOLD = 1,
    parameter int ODIM = 1,
    parameter int PIPE = 1,
    parameter int MODE = 0,
    localparam int N  = ODIM / FOLD * IDIM,
    localparam int FW = fold_w(FOLD)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_clr,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic          iBit [IDIM-1:0],
    input  logic          wBit [N-1:0],
    output logic          o_valid,
    input  logic          o_ready,
    output logic          oFmbs [N-1:0],
    output logic          enable [N-1:0],
    output logic [FW-1:0] o_fold,
    output logic          o_last
);

    if (ODIM % FOLD != 0 || PIPE < 1 || MODE > 1) begin : g_bad_cfg
        $error("fc_muldecomp_pipe: bad parameters ODIM=%0d FOLD=%0d PIPE=%0d MODE=%0d",
               ODIM, FOLD, PIPE, MODE);
    end

    logic                    stall;
    logic                    adv;
    logic                    accept;
    logic                    last0;
    logic [FW-1:0]           fold_cnt;
    logic [PIPE:0]           v;
    logic [PIPE:0]           l;
    logic [PIPE:0][N-1:0]    f;
    logic [PIPE:0][N-1:0]    e;
    logic [PIPE:0][FW-1:0]   fd;

    assign stall  = o_valid & ~o_ready;
    assign adv    = ~stall;
    assign i_ready = ~stall & ~i_clr;
    assign accept = i_valid & i_ready;
    assign last0  = (fold_cnt == FW'(FOLD - 1));

    for (genvar k = 0; k < N; k++) begin : g_syn
        assign f[0][k]   = (MODE == int'(MD_BIPOLAR)) ? ~(iBit[k % IDIM] ^ wBit[k])
                                                      : (iBit[k % IDIM] & wBit[k]);
        assign e[0][k]   = iBit[k % IDIM];
        assign oFmbs[k]  = f[PIPE][k];
        assign enable[k] = e[PIPE][k];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            fold_cnt <= '0;
        else if (i_clr)
            fold_cnt <= '0;
        else if (accept)
            fold_cnt <= last0 ? '0 : fold_cnt + 1'b1;
    end

    assign v[0]  = i_valid;
    assign fd[0] = fold_cnt;
    assign l[0]  = last0;

    for (genvar s = 0; s < PIPE; s++) begin : g_st
        fc_muldecomp_stage #(.N(N), .FW(FW)) u_stage (
            .clk      (clk),
            .rstn     (rstn),
            .flush    (i_clr),
            .adv      (adv),
            .in_valid (v[s]),
            .in_fm    (f[s]),
            .in_en    (e[s]),
            .in_fold  (fd[s]),
            .in_last  (l[s]),
            .out_valid(v[s+1]),
            .out_fm   (f[s+1]),
            .out_en   (e[s+1]),
            .out_fold (fd[s+1]),
            .out_last (l[s+1])
        );
    end

    assign o_valid = v[PIPE];
    assign o_fold  = fd[PIPE];
    // Gated so a stale last bit never shows on a bubble (FOLD==1 gives o_last == o_valid).
    assign o_last  = v[PIPE] & l[PIPE];

endmodule

// File: tb/tb_fc_muldecomp_pipe.sv
// tb_fc_muldecomp_pipe: three configurations driven in lockstep, checked every cycle against a
// tick-indexed beat history model plus hand-computed literal expectations.
module tb_fc_muldecomp_pipe;

    localparam int ND = 3;

    int pp [ND] = '{1, 1, 3};
    int fl [ND] = '{2, 2, 4};
    int md [ND] = '{0, 1, 0};

    logic clk = 1'b0;
    logic rstn, clr, iv, ordy;
    logic [1:0] ibp;
    logic [3:0] wbp;
    logic ib [1:0];
    logic wb [3:0];
    logic fm0 [3:0], fm1 [3:0], fm2 [3:0];
    logic en0 [3:0], en1 [3:0], en2 [3:0];
    logic [0:0] fd0, fd1;
    logic [1:0] fd2;
    logic ir0, ir1, ir2, ov0, ov1, ov2, ol0, ol1, ol2;
    logic [ND-1:0] irv, ovv, olv;
    logic [3:0] fmp [ND];
    logic [3:0] enp [ND];
    logic [1:0] fdp [ND];

    int tick [ND];
    int fcnt [ND];
    logic hv [ND][64];
    logic [3:0] hf [ND][64];
    logic [3:0] he [ND][64];
    int hd [ND][64];
    int vecs = 0;
    int errs = 0;
    int cnt;

    always #5 clk = ~clk;

    assign ib = '{ibp[1], ibp[0]};
    assign wb = '{wbp[3], wbp[2], wbp[1], wbp[0]};
    assign irv = {ir2, ir1, ir0};
    assign ovv = {ov2, ov1, ov0};
    assign olv = {ol2, ol1, ol0};
    assign fmp[0] = {fm0[3], fm0[2], fm0[1], fm0[0]};
    assign fmp[1] = {fm1[3], fm1[2], fm1[1], fm1[0]};
    assign fmp[2] = {fm2[3], fm2[2], fm2[1], fm2[0]};
    assign enp[0] = {en0[3], en0[2], en0[1], en0[0]};
    assign enp[1] = {en1[3], en1[2], en1[1], en1[0]};
    assign enp[2] = {en2[3], en2[2], en2[1], en2[0]};
    assign fdp[0] = {1'b0, fd0};
    assign fdp[1] = {1'b0, fd1};
    assign fdp[2] = fd2;

    fc_muldecomp_pipe #(.IDIM(2), .FOLD(2), .ODIM(4), .PIPE(1), .MODE(0)) u_d0 (
        .clk(clk), .rstn(rstn), .i_clr(clr), .i_valid(iv), .i_ready(ir0), .iBit(ib), .wBit(wb),
        .o_valid(ov0), .o_ready(ordy), .oFmbs(fm0), .enable(en0), .o_fold(fd0), .o_last(ol0));

    fc_muldecomp_pipe #(.IDIM(2), .FOLD(2), .ODIM(4), .PIPE(1), .MODE(1)) u_d1 (
        .clk(clk), .rstn(rstn), .i_clr(clr), .i_valid(iv), .i_ready(ir1), .iBit(ib), .wBit(wb),
        .o_valid(ov1), .o_ready(ordy), .oFmbs(fm1), .enable(en1), .o_fold(fd1), .o_last(ol1));

    fc_muldecomp_pipe #(.IDIM(2), .FOLD(4), .ODIM(8), .PIPE(3), .MODE(0)) u_d2 (
        .clk(clk), .rstn(rstn), .i_clr(clr), .i_valid(iv), .i_ready(ir2), .iBit(ib), .wBit(wb),
        .o_valid(ov2), .o_ready(ordy), .oFmbs(fm2), .enable(en2), .o_fold(fd2), .o_last(ol2));

    function automatic logic [3:0] mfm(int d, logic [1:0] b, logic [3:0] w);
        logic [3:0] r;
        for (int k = 0; k < 4; k++)
            r[k] = (md[d] == 1) ? ~(b[k % 2] ^ w[k]) : (b[k % 2] & w[k]);
        return r;
    endfunction

    function automatic logic [3:0] men(logic [1:0] b);
        return {b, b};
    endfunction

    // A beat written at tick t is at the output once PIPE further ticks (non-stalled cycles) pass.
    function automatic bit mv(int d);
        int t;
        t = tick[d] - pp[d];
        return (t >= 0) && hv[d][t % 64];
    endfunction

    task automatic mclear(int d);
        for (int i = 0; i < 64; i++) hv[d][i] = 1'b0;
        fcnt[d] = 0;
    endtask

    task automatic chk(string nm, int d, int act, int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s dut%0d @%0t: actual=%0h required=%0h", nm, d, $time, act, exp);
        end
    endtask

    task automatic check_out();
        for (int d = 0; d < ND; d++) begin
            int t;
            int ix;
            bit ev;
            t  = tick[d] - pp[d];
            ix = (t < 0) ? 0 : t % 64;
            ev = mv(d);
            chk("o_valid", d, ovv[d], ev);
            chk("o_last", d, olv[d], ev && (hd[d][ix] == fl[d] - 1));
            if (ev) begin
                chk("oFmbs", d, fmp[d], hf[d][ix]);
                chk("enable", d, enp[d], he[d][ix]);
                chk("o_fold", d, fdp[d], hd[d][ix]);
            end
        end
    endtask

    task automatic step();
        bit st [ND];
        #1;
        for (int d = 0; d < ND; d++) begin
            st[d] = mv(d) && !ordy;
            chk("i_ready", d, irv[d], !st[d] && !clr);
        end
        @(posedge clk);
        for (int d = 0; d < ND; d++) begin
            int ix;
            ix = tick[d] % 64;
            if (clr) begin
                mclear(d);
                tick[d]++;
            end else if (!st[d]) begin
                hv[d][ix] = iv;
                if (iv) begin
                    hf[d][ix] = mfm(d, ibp, wbp);
                    he[d][ix] = men(ibp);
                    hd[d][ix] = fcnt[d];
                    fcnt[d] = (fcnt[d] + 1) % fl[d];
                end
                tick[d]++;
            end
        end
        #1;
        check_out();
    endtask

    task automatic areset();
        rstn = 1'b0;
        for (int d = 0; d < ND; d++) mclear(d);
        #1;
        for (int d = 0; d < ND; d++) begin
            chk("rst_valid", d, ovv[d], 0);
            chk("rst_fm", d, fmp[d], 0);
            chk("rst_en", d, enp[d], 0);
            chk("rst_fold", d, fdp[d], 0);
            chk("rst_last", d, olv[d], 0);
            chk("rst_ready", d, irv[d], 1);
        end
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
    endtask

    initial begin
        clr = 1'b0; iv = 1'b0; ordy = 1'b1; ibp = '0; wbp = '0;
        for (int d = 0; d < ND; d++) begin
            tick[d] = 0;
            mclear(d);
        end
        rstn = 1'b1;
        #1 areset();

        iv = 1'b1; ibp = 2'b01; wbp = 4'b1111;
        step();
        chk("lit_fm", 0, fmp[0], 4'b0101);
        chk("lit_en", 0, enp[0], 4'b0101);
        chk("lit_fold0", 0, fdp[0], 0);
        chk("lit_last0", 0, olv[0], 0);
        chk("lit_lat1", 2, ovv[2], 0);
        wbp = 4'b0110;
        step();
        chk("lit_fold1", 0, fdp[0], 1);
        chk("lit_last1", 0, olv[0], 1);
        chk("lit_bipolar", 1, fmp[1], 4'b1100);
        chk("lit_lat2", 2, ovv[2], 0);
        wbp = 4'b1010;
        step();
        chk("lit_wrap", 0, fdp[0], 0);
        chk("lit_lat3", 2, ovv[2], 1);
        chk("lit_d2fm", 2, fmp[2], 4'b0101);
        chk("lit_d2fold", 2, fdp[2], 0);

        iv = 1'b0;
        repeat (4) step();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            iv = 1'b1; ibp = 2'(i); wbp = 4'(i * 5 + 3);
            step();
            cnt += int'(ovv[2]);
        end
        iv = 1'b0;
        repeat (4) begin
            step();
            cnt += int'(ovv[2]);
        end
        chk("burst_cnt", 2, cnt, 10);

        for (int i = 0; i < 5; i++) begin
            iv = 1'b1; ibp = 2'(i + 1); wbp = 4'(i * 3 + 7);
            step();
        end
        ordy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ibp = 2'(i); wbp = 4'(15 - i);
            step();
        end
        chk("stall_ready", 2, irv[2], 0);
        ordy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ibp = 2'(3 - i); wbp = 4'(i * 6 + 1);
            step();
        end
        iv = 1'b0;
        repeat (4) step();

        for (int i = 0; i < 2; i++) begin
            iv = 1'b1; ibp = 2'(i + 2); wbp = 4'(i + 9);
            step();
        end
        clr = 1'b1; iv = 1'b1; ibp = 2'b11; wbp = 4'b1111;
        #1 chk("clr_ready", 2, irv[2], 0);
        step();
        chk("clr_valid", 2, ovv[2], 0);
        chk("clr_valid", 0, ovv[0], 0);
        clr = 1'b0; iv = 1'b1; ibp = 2'b11; wbp = 4'b1001;
        step();
        chk("clr_fold_p1", 0, fdp[0], 0);
        iv = 1'b0;
        step();
        step();
        chk("clr_valid3", 2, ovv[2], 1);
        chk("clr_fold", 2, fdp[2], 0);

        for (int i = 0; i < 4; i++) begin
            iv = 1'b1; ibp = 2'(i); wbp = 4'(i * 4 + 2);
            step();
        end
        ordy = 1'b0;
        step();
        step();
        #3 areset();
        ordy = 1'b1; iv = 1'b1; ibp = 2'b10; wbp = 4'b1110;
        step();
        chk("post_rst_valid", 0, ovv[0], 1);
        chk("post_rst_fold", 0, fdp[0], 0);
        chk("post_rst_fm", 0, fmp[0], 4'b1010);
        iv = 1'b0;
        step();
        step();
        chk("post_rst_valid", 2, ovv[2], 1);
        chk("post_rst_fold", 2, fdp[2], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
